// File: rtl/camera_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : camera_pattern_gen
// Purpose  : Parallel-camera (pclk/vsync/href/data) test-pattern source.
// Revision : 1.0
// ============================================================================
module camera_pattern_gen #(
  parameter int ACTIVE_W    = 640,
  parameter int ACTIVE_H    = 480,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10,
  parameter int PCLK_DIV    = 4,
  parameter int BPP         = 2,
  parameter int BOX         = 64
) (
  input  logic        clk100,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [15:0] const_rgb,
  output logic        sim_pclk,
  output logic        sim_vsync,
  output logic        sim_href,
  output logic [7:0]  sim_data,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        busy
);

  localparam int LINE_BYTES = ACTIVE_W * BPP;
  localparam int LINE_LEN   = LINE_BYTES + H_BLANK;
  localparam int MAX_A      = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int MAX_B      = (ACTIVE_H > V_FRONT) ? ACTIVE_H : V_FRONT;
  localparam int MAX_LINES  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int HW         = $clog2(LINE_LEN + 1);
  localparam int VW         = $clog2(MAX_LINES + 1);
  localparam int DW         = $clog2(PCLK_DIV);
  localparam int BAR_W      = (ACTIVE_W / 8 > 0) ? ACTIVE_W / 8 : 1;
  localparam int BOX_Y      = (ACTIVE_H - BOX) / 2;
  localparam int BX_STEP    = 4;

  localparam logic [HW-1:0] H_LAST   = HW'(LINE_LEN - 1);
  localparam logic [VW-1:0] VS_LAST  = VW'(VSYNC_LINES - 1);
  localparam logic [VW-1:0] VB_LAST  = VW'(V_BACK - 1);
  localparam logic [VW-1:0] VA_LAST  = VW'(ACTIVE_H - 1);
  localparam logic [VW-1:0] VF_LAST  = VW'(V_FRONT - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(PCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_PRE  = DW'(PCLK_DIV - 2);
  localparam logic [DW-1:0] DIV_HALF = DW'(PCLK_DIV / 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_VSYNC  = 3'd1,
    S_VBACK  = 3'd2,
    S_ACTIVE = 3'd3,
    S_VFRONT = 3'd4
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [DW-1:0]   div;
  logic [DW-1:0]   div_n;
  logic [HW-1:0]   hcnt;
  logic [HW-1:0]   hcnt_n;
  logic [VW-1:0]   vcnt;
  logic [VW-1:0]   vcnt_n;
  logic [1:0]      mode_q;
  logic [15:0]     rgb_q;
  logic [15:0]     bx;
  logic [15:0]     bx_n;
  logic            pclk_fall;
  logic            pre_fall;
  logic            line_end;
  logic            last_cycle;

  // Line/frame sequencing: everything advances on the pclk falling edge.
  always_comb begin
    pclk_fall  = (state != S_IDLE) && (div == DIV_LAST);
    pre_fall   = (state != S_IDLE) && (div == DIV_PRE);
    div_n      = (div == DIV_LAST) ? '0 : div + DW'(1);
    line_end   = (hcnt == H_LAST);
    hcnt_n     = line_end ? '0 : hcnt + HW'(1);
    vcnt_n     = vcnt;
    state_n    = state;
    if (line_end) begin
      vcnt_n = vcnt + VW'(1);
      case (state)
        S_VSYNC:  if (vcnt == VS_LAST) begin state_n = S_VBACK;  vcnt_n = '0; end
        S_VBACK:  if (vcnt == VB_LAST) begin state_n = S_ACTIVE; vcnt_n = '0; end
        S_ACTIVE: if (vcnt == VA_LAST) begin state_n = S_VFRONT; vcnt_n = '0; end
        S_VFRONT: if (vcnt == VF_LAST) begin
          state_n = enable ? S_VSYNC : S_IDLE;
          vcnt_n  = '0;
        end
        default: vcnt_n = '0;
      endcase
    end
    last_cycle = pre_fall && (state == S_VFRONT) && line_end && (vcnt == VF_LAST);
    bx_n = (int'(bx) + BX_STEP + BOX > ACTIVE_W) ? '0 : bx + 16'(BX_STEP);
  end

  logic [15:0] px;
  logic [15:0] py;
  logic [2:0]  bar;
  logic [15:0] bar_rgb;
  logic        in_box;
  logic [15:0] rgb;
  logic        href_n;
  logic [7:0]  byte_n;

  // Pixel colour for the pclk cycle that starts at the next falling edge.
  always_comb begin
    px      = 16'(int'(hcnt_n) / BPP);
    py      = 16'(vcnt_n);
    bar     = 3'(int'(px) / BAR_W);
    bar_rgb = '0;
    case (bar)
      3'd0: bar_rgb = 16'hFFFF;
      3'd1: bar_rgb = 16'hFFE0;
      3'd2: bar_rgb = 16'h07FF;
      3'd3: bar_rgb = 16'h07E0;
      3'd4: bar_rgb = 16'hF81F;
      3'd5: bar_rgb = 16'hF800;
      3'd6: bar_rgb = 16'h001F;
      3'd7: bar_rgb = 16'h0000;
    endcase
    in_box = (px >= bx) && (px < bx + 16'(BOX)) &&
             (py >= 16'(BOX_Y)) && (py < 16'(BOX_Y + BOX));
    rgb = '0;
    case (mode_q)
      2'd0: rgb = bar_rgb;
      2'd1: rgb = {px[7:3], px[7:2], px[7:3]};
      2'd2: rgb = rgb_q;
      2'd3: rgb = in_box ? rgb_q : 16'h0000;
    endcase
    href_n = (state_n == S_ACTIVE) && (int'(hcnt_n) < LINE_BYTES);
    byte_n = ((BPP == 2) && hcnt_n[0]) ? rgb[7:0] : rgb[15:8];
  end

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      div        <= '0;
      hcnt       <= '0;
      vcnt       <= '0;
      mode_q     <= '0;
      rgb_q      <= '0;
      bx         <= '0;
      sim_pclk   <= 1'b0;
      sim_vsync  <= 1'b0;
      sim_href   <= 1'b0;
      sim_data   <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      busy       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state == S_IDLE) begin
        div      <= '0;
        sim_pclk <= 1'b0;
        if (enable) begin
          // The start edge plays the role of a pclk falling edge.
          state     <= S_VSYNC;
          hcnt      <= '0;
          vcnt      <= '0;
          mode_q    <= mode;
          rgb_q     <= const_rgb;
          sim_vsync <= 1'b1;
          sim_href  <= 1'b0;
          sim_data  <= '0;
          busy      <= 1'b1;
        end
      end else begin
        div      <= div_n;
        sim_pclk <= (div_n >= DIV_HALF);
        if (last_cycle) begin
          frame_done <= 1'b1;
          frame_cnt  <= frame_cnt + 16'd1;
          bx         <= bx_n;
        end
        if (pclk_fall) begin
          state     <= state_n;
          hcnt      <= hcnt_n;
          vcnt      <= vcnt_n;
          sim_vsync <= (state_n == S_VSYNC);
          sim_href  <= href_n;
          sim_data  <= href_n ? byte_n : 8'h00;
          busy      <= (state_n != S_IDLE);
          if (state_n == S_VSYNC) begin
            mode_q <= mode;
            rgb_q  <= const_rgb;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_camera_pattern_gen.sv
`default_nettype none
// Scoreboard bench for camera_pattern_gen in its small configuration
// (8x4 active, L=20 pclk, 280 clk100 per frame).
module tb_camera_pattern_gen;

  localparam logic [127:0] BARS  = 128'hFFFF_FFE0_07FF_07E0_F81F_F800_001F_0000;
  localparam logic [127:0] CONST = 128'h1234_1234_1234_1234_1234_1234_1234_1234;
  localparam logic [127:0] BOX0  = 128'hF800_F800_0000_0000_0000_0000_0000_0000;
  localparam logic [127:0] BOX4  = 128'h0000_0000_0000_0000_F800_F800_0000_0000;
  localparam logic [127:0] ZERO  = 128'h0;

  logic        clk100 = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] const_rgb = 16'h0000;
  logic        sim_pclk;
  logic        sim_vsync;
  logic        sim_href;
  logic [7:0]  sim_data;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic        busy;

  camera_pattern_gen #(
    .ACTIVE_W(8), .ACTIVE_H(4), .H_BLANK(4), .VSYNC_LINES(1), .V_BACK(1),
    .V_FRONT(1), .PCLK_DIV(2), .BPP(2), .BOX(2)
  ) dut (
    .clk100(clk100), .rst_n(rst_n), .enable(enable), .mode(mode),
    .const_rgb(const_rgb), .sim_pclk(sim_pclk), .sim_vsync(sim_vsync),
    .sim_href(sim_href), .sim_data(sim_data), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .busy(busy)
  );

  always #5 clk100 = ~clk100;

  int checks = 0;
  int failures = 0;
  logic [7:0]  exp_bytes[$];
  logic [15:0] exp_cnt[$];
  bit          exp_per[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_line(input logic [127:0] l);
    for (int i = 0; i < 16; i++) exp_bytes.push_back(l[127-8*i -: 8]);
  endtask

  task automatic push_frame(input logic [127:0] l0, input logic [127:0] l1,
                            input logic [127:0] l2, input logic [127:0] l3);
    push_line(l0); push_line(l1); push_line(l2); push_line(l3);
  endtask

  // Monitor: bytes at each pclk rise, frame_done events, vsync width.
  initial begin
    int   cyc;
    int   last_done;
    int   vs_run;
    logic prev_pclk;
    cyc = 0; last_done = 0; vs_run = 0; prev_pclk = 1'b0;
    forever begin
      @(negedge clk100);
      cyc++;
      if (sim_pclk && !prev_pclk) begin
        if (sim_href) begin
          if (exp_bytes.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_byte actual=%0h required=none", sim_data);
          end else begin
            check("pixel_byte", 32'(sim_data), 32'(exp_bytes.pop_front()));
          end
        end else begin
          check("blank_data", 32'(sim_data), 32'h0);
        end
        if (sim_vsync) vs_run++;
        else if (vs_run != 0) begin
          check("vsync_width", 32'(vs_run), 32'd20);
          vs_run = 0;
        end
      end
      prev_pclk = sim_pclk;
      if (frame_done) begin
        if (exp_cnt.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_frame_done actual=%0h required=none", frame_cnt);
        end else begin
          check("frame_cnt", 32'(frame_cnt), 32'(exp_cnt.pop_front()));
          if (exp_per.pop_front()) check("frame_period", 32'(cyc - last_done), 32'd280);
        end
        last_done = cyc;
      end
    end
  end

  task automatic wait_href();
    int n;
    n = 0;
    do begin @(negedge clk100); n++; end while (!sim_href && n < 600);
    if (!sim_href) begin
      checks++; failures++;
      $display("FAIL href_timeout actual=0 required=1");
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin @(negedge clk100); n++; end while (!frame_done && n < 600);
    if (!frame_done) begin
      checks++; failures++;
      $display("FAIL frame_done_timeout actual=0 required=1");
    end
  endtask

  task automatic check_idle(input string name);
    int highs;
    highs = 0;
    repeat (2) @(negedge clk100);
    check(name, 32'(busy), 32'h0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk100);
      if (sim_pclk || busy) highs++;
    end
    check("idle_pclk_held", 32'(highs), 32'h0);
  endtask

  initial begin
    repeat (3) @(negedge clk100);
    check("reset_pclk",  32'(sim_pclk),  32'h0);
    check("reset_vsync", 32'(sim_vsync), 32'h0);
    check("reset_href",  32'(sim_href),  32'h0);
    check("reset_data",  32'(sim_data),  32'h0);
    check("reset_done",  32'(frame_done), 32'h0);
    check("reset_cnt",   32'(frame_cnt), 32'h0);
    check("reset_busy",  32'(busy),      32'h0);

    // Frames 0..5: bars, constant, then box at bx 0,4,0,4.
    push_frame(BARS, BARS, BARS, BARS);
    push_frame(CONST, CONST, CONST, CONST);
    push_frame(ZERO, BOX0, BOX0, ZERO);
    push_frame(ZERO, BOX4, BOX4, ZERO);
    push_frame(ZERO, BOX0, BOX0, ZERO);
    push_frame(ZERO, BOX4, BOX4, ZERO);
    for (int i = 1; i <= 6; i++) begin
      exp_cnt.push_back(16'(i));
      exp_per.push_back(i > 1);
    end

    mode = 2'd0; const_rgb = 16'h1234; enable = 1'b1; rst_n = 1'b1;
    @(negedge clk100);
    check("busy_after_start", 32'(busy), 32'h1);
    wait_href();
    mode = 2'd2;
    wait_done();
    wait_href();
    mode = 2'd3; const_rgb = 16'hF800;
    repeat (4) wait_done();
    wait_href();
    enable = 1'b0;
    wait_done();
    check_idle("busy_after_stop");

    // Reset mid-line, then a clean frame from zero.
    mode = 2'd0; enable = 1'b1;
    push_frame(BARS, BARS, BARS, BARS);
    wait_href();
    repeat (3) @(negedge clk100);
    rst_n = 1'b0;
    #1;
    check("abort_pclk",  32'(sim_pclk),  32'h0);
    check("abort_vsync", 32'(sim_vsync), 32'h0);
    check("abort_href",  32'(sim_href),  32'h0);
    check("abort_data",  32'(sim_data),  32'h0);
    check("abort_busy",  32'(busy),      32'h0);
    check("abort_cnt",   32'(frame_cnt), 32'h0);
    repeat (2) @(negedge clk100);
    exp_bytes.delete();
    push_frame(BARS, BARS, BARS, BARS);
    exp_cnt.push_back(16'd1);
    exp_per.push_back(1'b0);
    rst_n = 1'b1;
    @(negedge clk100);
    check("busy_after_reset", 32'(busy), 32'h1);
    wait_href();
    enable = 1'b0;
    wait_done();
    check_idle("busy_final");
    check("bytes_left", 32'(exp_bytes.size()), 32'h0);
    check("frames_left", 32'(exp_cnt.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
